// File: rtl/axis_image_header_packer.sv
// Image-stream transmitter: one header beat built from the latched config, then cfg_beats_1+1 pixel beats.
// Optional define AXIS_IMAGE_HEADER_PACKER_TLAST_CHECK_EN adds s_axis_tlast and a sticky err_tlast flag.
module axis_image_header_packer #(
    parameter int UNITS              = 2,
    parameter int WORD_WIDTH         = 8,
    parameter int KERNEL_H_MAX       = 3,
    parameter int I_IMAGE_IS_NOT_MAX = 0,
    parameter int I_IMAGE_IS_MAX     = 1,
    parameter int I_IMAGE_IS_LRELU   = 2,
    parameter int I_IMAGE_KERNEL_H_1 = 3,
    parameter int BEATS_WIDTH        = 16,
    localparam int WORDS = 2**$clog2(UNITS + KERNEL_H_MAX - 1),
    localparam int DW    = WORD_WIDTH * WORDS,
    localparam int KW    = $clog2(KERNEL_H_MAX)
) (
    input  logic                   aclk,
    input  logic                   aresetn,

    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic                   cfg_is_max,
    input  logic                   cfg_is_lrelu,
    input  logic [KW-1:0]          cfg_kernel_h_1,
    input  logic [BEATS_WIDTH-1:0] cfg_beats_1,

`ifdef AXIS_IMAGE_HEADER_PACKER_TLAST_CHECK_EN
    input  logic                   s_axis_tlast,
    output logic                   err_tlast,
`endif

    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [DW-1:0]          s_axis_tdata,

    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DW-1:0]          m_axis_tdata,
    output logic [DW/8-1:0]        m_axis_tkeep,
    output logic                   m_axis_tlast
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        PASS   = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic                   is_max_q;
    logic                   is_lrelu_q;
    logic [KW-1:0]          kernel_h_1_q;
    logic [BEATS_WIDTH-1:0] beats_1_q;
    logic [BEATS_WIDTH-1:0] count;

    logic                   load_en;
    logic                   latch_cfg;
    logic                   load_hdr;
    logic                   load_pix;
    logic                   pix_last;
    logic [DW-1:0]          hdr_data;

    // The output register can take a new beat when it is empty or being drained this cycle.
    assign load_en      = !m_axis_tvalid || m_axis_tready;
    assign pix_last     = (count == beats_1_q);
    assign m_axis_tkeep = '1;

    always_comb begin
        hdr_data = '0;
        hdr_data[I_IMAGE_IS_NOT_MAX*WORD_WIDTH +: WORD_WIDTH] = WORD_WIDTH'(!is_max_q);
        hdr_data[I_IMAGE_IS_MAX*WORD_WIDTH     +: WORD_WIDTH] = WORD_WIDTH'(is_max_q);
        hdr_data[I_IMAGE_IS_LRELU*WORD_WIDTH   +: WORD_WIDTH] = WORD_WIDTH'(is_lrelu_q);
        hdr_data[I_IMAGE_KERNEL_H_1*WORD_WIDTH +: WORD_WIDTH] = WORD_WIDTH'(kernel_h_1_q);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        cfg_ready     = 1'b0;
        s_axis_tready = 1'b0;
        latch_cfg     = 1'b0;
        load_hdr      = 1'b0;
        load_pix      = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    latch_cfg  = 1'b1;
                    state_next = HEADER;
                end
            end
            HEADER: begin
                if (load_en) begin
                    load_hdr   = 1'b1;
                    state_next = PASS;
                end
            end
            PASS: begin
                s_axis_tready = load_en;
                if (s_axis_tvalid && load_en) begin
                    load_pix = 1'b1;
                    if (pix_last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            is_max_q     <= 1'b0;
            is_lrelu_q   <= 1'b0;
            kernel_h_1_q <= '0;
            beats_1_q    <= '0;
        end else if (latch_cfg) begin
            is_max_q     <= cfg_is_max;
            is_lrelu_q   <= cfg_is_lrelu;
            kernel_h_1_q <= cfg_kernel_h_1;
            beats_1_q    <= cfg_beats_1;
        end
    end

    // The final beat resets the count instead of incrementing, so it can never wrap.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count <= '0;
        end else if (load_hdr) begin
            count <= '0;
        end else if (load_pix) begin
            count <= pix_last ? '0 : count + BEATS_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load_hdr) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= hdr_data;
            m_axis_tlast  <= 1'b0;
        end else if (load_pix) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tlast  <= pix_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef AXIS_IMAGE_HEADER_PACKER_TLAST_CHECK_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_tlast <= 1'b0;
        end else if (latch_cfg) begin
            err_tlast <= 1'b0;
        end else if (load_pix && (s_axis_tlast != pix_last)) begin
            err_tlast <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/axis_image_header_packer.md
AXIS_IMAGE_HEADER_PACKER -- requirements
Module: axis_image_header_packer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- UNITS, 2: conv units.
- WORD_WIDTH, 8: bits per word.
- KERNEL_H_MAX, 3: odd maximum kernel height.
- I_IMAGE_IS_NOT_MAX, 0: header word index of the not-max flag.
- I_IMAGE_IS_MAX, 1: header word index of the max flag.
- I_IMAGE_IS_LRELU, 2: header word index of the lrelu flag.
- I_IMAGE_KERNEL_H_1, 3: header word index of kernel_h-1.
- BEATS_WIDTH, 16: pixel beat counter width.
REQ-002 Derived values: WORDS = 2**$clog2(UNITS+KERNEL_H_MAX-1); DW = WORD_WIDTH*WORDS; KW = $clog2(KERNEL_H_MAX).
REQ-003 Ports (name, direction, width, meaning):
- aclk, in, 1: clock.
- aresetn, in, 1: reset; one clock, asynchronous, active-low.
- cfg_valid, in, 1: config offered.
- cfg_ready, out, 1: config accepted.
- cfg_is_max, in, 1: maxpool flag.
- cfg_is_lrelu, in, 1: leaky-relu flag.
- cfg_kernel_h_1, in, KW: kernel height minus 1.
- cfg_beats_1, in, BEATS_WIDTH: pixel beats minus 1.
- s_axis_tvalid, in, 1: pixel valid.
- s_axis_tready, out, 1: pixel ready.
- s_axis_tdata, in, DW: pixel words.
- m_axis_tvalid, out, 1: output valid.
- m_axis_tready, in, 1: output ready.
- m_axis_tdata, out, DW: output words.
- m_axis_tkeep, out, DW/8: byte enables.
- m_axis_tlast, out, 1: end of image.

Function
REQ-004 The block SHALL be the transmitter of the image input stream: per image, it emits one header beat followed by cfg_beats_1+1 pixel beats, with tlast on the final pixel beat.
REQ-005 The FSM SHALL have three states: IDLE, HEADER and PASS.
REQ-006 IDLE: cfg_ready=1 and s_axis_tready=0; a cfg handshake latches all cfg_* fields and moves to HEADER.
REQ-007 HEADER: the block SHALL load the header beat into the output register when the register is empty or being drained; it then moves to PASS with beat count=0; s_axis_tready=0.
REQ-008 Header tdata SHALL be built as follows:
- word[I_IMAGE_IS_NOT_MAX] = !is_max.
- word[I_IMAGE_IS_MAX] = is_max.
- word[I_IMAGE_IS_LRELU] = is_lrelu.
- word[I_IMAGE_KERNEL_H_1] = kernel_h_1, zero-extended.
- All other words SHALL be 0.
- Header tlast SHALL be 0.
REQ-009 PASS: s_axis_tready = !m_axis_tvalid || m_axis_tready; each accepted pixel beat SHALL be loaded unmodified into the output register with tlast=(count==beats_1), then count increments.
REQ-010 Acceptance of the beat with count==beats_1 SHALL return the FSM to IDLE; the next cfg SHALL be accepted no earlier than the following cycle.
REQ-011 The output SHALL be a single pipeline register: latency from s handshake to m_axis_tvalid is 1 cycle, with full throughput under continuous ready.
REQ-012 While m_axis_tvalid=1 and m_axis_tready=0, tdata, tkeep and tlast SHALL hold stable.
REQ-013 m_axis_tkeep SHALL be all ones on every beat.
REQ-014 cfg_beats_1=0 SHALL produce a header beat followed by exactly one pixel beat with tlast=1.
REQ-015 The count SHALL never wrap; the beat with count==beats_1 always terminates the image.
REQ-016 cfg_* inputs SHALL be ignored outside IDLE; s_axis beats SHALL not be consumed outside PASS.

Reset
REQ-017 On aresetn low, asynchronously:
- FSM = IDLE.
- count = 0.
- Latched config = 0.
- m_axis_tvalid = 0, tdata = 0, tlast = 0.
REQ-018 Reset asserted mid-image SHALL abandon the image; after release, the block waits for a new cfg and emits no partial tail.

Configuration
REQ-019 Macro AXIS_IMAGE_HEADER_PACKER_TLAST_CHECK_EN:
- When defined, the block SHALL add input s_axis_tlast (1) and output err_tlast (1).
- err_tlast SHALL be set, sticky, on any accepted pixel beat where s_axis_tlast != (count==beats_1).
- err_tlast SHALL clear on a cfg handshake and on reset.
- When not defined, neither port exists and s_axis_tlast is not sampled.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Config: is_max=1, lrelu=0, kernel_h_1=2, beats_1=3; all ready high -> 5 beats out. Header words [0]=0, [1]=1, [2]=0, [3]=2, rest 0. tlast only on beat 5. Header appears 1 cycle after cfg handshake.
- beats_1=0, is_max=0 -> header with word[0]=1, then one pixel beat with tlast=1; cfg_ready returns to 1 afterwards.
- m_axis_tready toggled 1/0 every cycle and s_axis_tvalid randomized over 8 beats -> output equals input order, no drops or duplicates, held data stable while stalled.
- Reset pulsed after the 2nd of 4 pixel beats -> m_axis_tvalid=0 immediately; the next image starts with a header.
- With the macro defined, s_axis_tlast=1 on beat 2 of beats_1=3 -> err_tlast=1 from the next cycle and stays set until the next cfg handshake.
- Two back-to-back images (beats_1=1 and 2) with cfg_valid held high -> 2+3 output beats, two headers, and exactly 2 tlasts.
